multicycle_ctrl: RTL and testbench

- Multi-cycle control unit for the reduced RISC-V core.
- Fetches each instruction through an imem ready/request handshake and decodes it into a five-state sequence.
- Drives the ALU's 3-bit operation select and datapath strobes.
- Consumes the ALU's EQ flag to resolve beq/bne.
- Sits between the instruction/data memory ports and the datapath (register file, ALU, PC).

---
 rtl/ctrl_pkg.sv | 67 ++++++
 rtl/alu_decoder.sv | 61 ++++++
 rtl/multicycle_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
package ctrl_pkg;

  // Controller sequence states.
  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_t;

  // Instruction class derived from the opcode field alone.
  typedef enum logic [2:0] {
    OpcR,
    OpcI,
    OpcLw,
    OpcSw,
    OpcBr,
    OpcBad
  } op_class_t;

  // Supported opcodes.
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  // ALU operation select encodings.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Immediate format select encodings.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  // funct3 values the decoder recognises.
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  // Map an opcode onto its instruction class; unknown opcodes become OpcBad.
  function automatic op_class_t classify(input logic [6:0] opcode);
    op_class_t cls;
    case (opcode)
      OP_R:    cls = OpcR;
      OP_I:    cls = OpcI;
      OP_LW:   cls = OpcLw;
      OP_SW:   cls = OpcSw;
      OP_BR:   cls = OpcBr;
      default: cls = OpcBad;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder: picks the ALU select for an instruction class and
// flags funct3/funct7[5] combinations the core does not implement.
module alu_decoder
  import ctrl_pkg::*;
(
  input  op_class_t   op_class_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7_5_i,
  output logic [2:0]  alu_ctrl_o,
  output logic        legal_o
);

  // Per-class ALU select and funct legality.
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    legal_o    = 1'b0;
    case (op_class_i)
      OpcR: begin
        case (funct3_i)
          F3_ADD: begin
            alu_ctrl_o = funct7_5_i ? ALU_SUB : ALU_ADD;
            legal_o    = 1'b1;
          end
          F3_AND: begin
            alu_ctrl_o = ALU_AND;
            legal_o    = !funct7_5_i;
          end
          F3_OR: begin
            alu_ctrl_o = ALU_OR;
            legal_o    = !funct7_5_i;
          end
          F3_SLT: begin
            alu_ctrl_o = ALU_SLT;
            legal_o    = !funct7_5_i;
          end
          default: legal_o = 1'b0;
        endcase
      end
      OpcI: begin
        // Only addi; funct7_5 is an immediate bit here and is ignored.
        alu_ctrl_o = ALU_ADD;
        legal_o    = (funct3_i == F3_ADD);
      end
      OpcLw, OpcSw: begin
        // Address generation is always base + offset.
        alu_ctrl_o = ALU_ADD;
        legal_o    = (funct3_i == F3_WORD);
      end
      OpcBr: begin
        // Compare by subtraction; the ALU reports EQ.
        alu_ctrl_o = ALU_SUB;
        legal_o    = (funct3_i == F3_BEQ) || (funct3_i == F3_BNE);
      end
      default: begin
        alu_ctrl_o = ALU_ADD;
        legal_o    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit for the reduced RISC-V core. Fetches through the
// imem handshake, holds its own IR, and sequences EXEC/MEM/WB per instruction.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  // Instruction width; the field slicing below assumes 32.
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATAWIDTH-1:0] instr,
  input  logic                 imem_rdy,
  input  logic                 dmem_rdy,
  input  logic                 EQ,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 IRwrite,
  output logic                 PCwrite,
  output logic                 PCsrc,
  output logic [2:0]           ALUctrl,
  output logic                 ALUsrc,
  output logic [1:0]           ImmSrc,
  output logic                 RegWrite,
  output logic                 ResultSrc,
  output logic                 illegal
);

  state_t                 state_q, state_d;
  logic [DATAWIDTH-1:0]   ir_q, ir_d;

  op_class_t  op_class;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [2:0] dec_alu_ctrl;
  logic       dec_legal;
  logic       instr_legal;
  logic       br_taken;
  logic       exec_alu_src;
  logic [1:0] exec_imm_src;

  assign op_class = classify(ir_q[6:0]);
  assign funct3   = ir_q[14:12];
  assign funct7   = ir_q[31:25];

  // Register and rd fields belong to the datapath; the controller ignores them.
  logic unused_ir_fields;
  assign unused_ir_fields = ^{ir_q[24:15], ir_q[11:7]};

  alu_decoder u_alu_decoder (
    .op_class_i (op_class),
    .funct3_i   (funct3),
    .funct7_5_i (funct7[5]),
    .alu_ctrl_o (dec_alu_ctrl),
    .legal_o    (dec_legal)
  );

  // R-type also needs every funct7 bit other than bit 5 to be zero.
  assign instr_legal = dec_legal &&
                       !((op_class == OpcR) && ({funct7[6], funct7[4:0]} != 6'd0));

  // beq takes on EQ, bne on !EQ; only meaningful during EXEC of a branch.
  assign br_taken = (funct3 == F3_BNE) ? !EQ : EQ;

  // Operand source and immediate format for the EXEC/MEM address phase.
  always_comb begin
    exec_alu_src = 1'b0;
    exec_imm_src = IMM_I;
    case (op_class)
      OpcR: begin
        exec_alu_src = 1'b0;
        exec_imm_src = IMM_I;
      end
      OpcI, OpcLw: begin
        exec_alu_src = 1'b1;
        exec_imm_src = IMM_I;
      end
      OpcSw: begin
        exec_alu_src = 1'b1;
        exec_imm_src = IMM_S;
      end
      OpcBr: begin
        exec_alu_src = 1'b0;
        exec_imm_src = IMM_B;
      end
      default: begin
        exec_alu_src = 1'b0;
        exec_imm_src = IMM_I;
      end
    endcase
  end

  // State and IR registers; reset forces IDLE and a zero IR immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state and output decode; everything defaults low.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    IRwrite   = 1'b0;
    PCwrite   = 1'b0;
    PCsrc     = 1'b0;
    ALUctrl   = ALU_ADD;
    ALUsrc    = 1'b0;
    ImmSrc    = IMM_I;
    RegWrite  = 1'b0;
    ResultSrc = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      StIdle: begin
        state_d = StFetch;
      end

      StFetch: begin
        imem_req = 1'b1;
        if (imem_rdy) begin
          // Capture the word and advance PC to PC+4 in the same cycle.
          ir_d    = instr;
          IRwrite = 1'b1;
          PCwrite = 1'b1;
          PCsrc   = 1'b0;
          state_d = StDecode;
        end
      end

      StDecode: begin
        state_d = instr_legal ? StExec : StTrap;
      end

      StExec: begin
        ALUctrl = dec_alu_ctrl;
        ALUsrc  = exec_alu_src;
        ImmSrc  = exec_imm_src;
        case (op_class)
          OpcR, OpcI:   state_d = StWb;
          OpcLw, OpcSw: state_d = StMem;
          OpcBr: begin
            // Second PC write of the instruction, only when taken.
            PCwrite = br_taken;
            PCsrc   = br_taken;
            state_d = StFetch;
          end
          default:      state_d = StTrap;
        endcase
      end

      StMem: begin
        // Keep the address computation stable until the access completes.
        ALUctrl  = dec_alu_ctrl;
        ALUsrc   = exec_alu_src;
        ImmSrc   = exec_imm_src;
        dmem_req = 1'b1;
        dmem_we  = (op_class == OpcSw);
        if (dmem_rdy) begin
          state_d = (op_class == OpcLw) ? StWb : StFetch;
        end
      end

      StWb: begin
        RegWrite  = 1'b1;
        ResultSrc = (op_class == OpcLw);
        state_d   = StFetch;
      end

      StTrap: begin
        // Sticky until reset; no further memory requests.
        illegal = 1'b1;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases followed by random
// instructions, memory wait states and resets, checked cycle by cycle.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        imem_rdy;
  logic        dmem_rdy;
  logic        EQ;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        IRwrite;
  logic        PCwrite;
  logic        PCsrc;
  logic [2:0]  ALUctrl;
  logic        ALUsrc;
  logic [1:0]  ImmSrc;
  logic        RegWrite;
  logic        ResultSrc;
  logic        illegal;

  multicycle_ctrl #(.DATAWIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .imem_rdy  (imem_rdy),
    .dmem_rdy  (dmem_rdy),
    .EQ        (EQ),
    .imem_req  (imem_req),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .IRwrite   (IRwrite),
    .PCwrite   (PCwrite),
    .PCsrc     (PCsrc),
    .ALUctrl   (ALUctrl),
    .ALUsrc    (ALUsrc),
    .ImmSrc    (ImmSrc),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector, MSB first:
  // imem_req dmem_req dmem_we IRwrite PCwrite PCsrc ALUctrl[2:0] ALUsrc ImmSrc[1:0]
  // RegWrite ResultSrc illegal
  logic [14:0] obs;
  assign obs = {imem_req, dmem_req, dmem_we, IRwrite, PCwrite, PCsrc, ALUctrl, ALUsrc,
                ImmSrc, RegWrite, ResultSrc, illegal};

  // Masks: which outputs carry a defined value in a given cycle.
  localparam logic [14:0] M_ALL   = 15'h7FFF;  // every output
  localparam logic [14:0] M_CTL   = 15'h7C05;  // requests, strobes, illegal
  localparam logic [14:0] M_FETCH = 15'h7E05;  // plus PCsrc
  localparam logic [14:0] M_WB    = 15'h7C07;  // plus ResultSrc
  localparam logic [14:0] M_EXT   = 15'h7FFD;  // all but ResultSrc
  localparam logic [14:0] M_EXNT  = 15'h7DFD;  // all but ResultSrc and PCsrc

  localparam int K_R  = 0;
  localparam int K_I  = 1;
  localparam int K_LW = 2;
  localparam int K_SW = 3;
  localparam int K_BR = 4;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [14:0] got, input logic [14:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic rb();
    return $urandom_range(0, 1) == 1;
  endfunction

  function automatic logic [14:0] mk(input logic imq, input logic dq, input logic we,
                                     input logic irw, input logic pcw, input logic pcs,
                                     input logic [2:0] ac, input logic as,
                                     input logic [1:0] im, input logic rw,
                                     input logic rs, input logic ill);
    return {imq, dq, we, irw, pcw, pcs, ac, as, im, rw, rs, ill};
  endfunction

  // Reference decode straight from the supported-instruction table.
  function automatic void ref_decode(input logic [31:0] ins, output bit legal,
                                     output int kind, output logic [2:0] ac);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op    = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    legal = 1'b0;
    kind  = K_R;
    ac    = 3'b000;
    case (op)
      7'b0110011: begin
        kind = K_R;
        if (f7 == 7'h00) begin
          case (f3)
            3'b000: begin legal = 1'b1; ac = 3'b000; end
            3'b111: begin legal = 1'b1; ac = 3'b010; end
            3'b110: begin legal = 1'b1; ac = 3'b011; end
            3'b010: begin legal = 1'b1; ac = 3'b101; end
            default: legal = 1'b0;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'b000) begin
          legal = 1'b1;
          ac    = 3'b001;
        end
      end
      7'b0010011: begin kind = K_I;  legal = (f3 == 3'b000); ac = 3'b000; end
      7'b0000011: begin kind = K_LW; legal = (f3 == 3'b010); ac = 3'b000; end
      7'b0100011: begin kind = K_SW; legal = (f3 == 3'b010); ac = 3'b000; end
      7'b1100011: begin kind = K_BR; legal = (f3 <= 3'b001); ac = 3'b001; end
      default:    legal = 1'b0;
    endcase
  endfunction

  // One clock: drive inputs just after the rising edge, check at the falling edge.
  task automatic tick(input string tag, input logic ir, input logic dr, input logic [31:0] iw,
                      input logic eqv, input logic [14:0] exp, input logic [14:0] msk);
    imem_rdy = ir;
    dmem_rdy = dr;
    instr    = iw;
    EQ       = eqv;
    @(negedge clk);
    check_eq(tag, obs & msk, exp & msk);
    @(posedge clk);
    #1;
  endtask

  // Assert reset inside the current cycle, check outputs drop at once, then
  // release and check one IDLE cycle. Returns with the DUT about to fetch.
  task automatic async_reset(input string tag);
    #1 rst_n = 1'b0;
    #1 check_eq(tag, obs, 15'h0000);
    @(negedge clk);
    check_eq({tag, "_hold"}, obs, 15'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick("idle", rb(), rb(), $urandom, rb(), 15'h0000, M_ALL);
  endtask

  // Execute one instruction from FETCH entry with the given wait states.
  task automatic run_instr(input logic [31:0] ins, input int iw, input int dw,
                           input logic eqv, input int rst_at);
    bit          legal;
    int          kind;
    logic [2:0]  ac;
    logic        taken;
    logic        is_sw;
    logic [1:0]  imm;
    logic [14:0] e;
    ref_decode(ins, legal, kind, ac);

    for (int i = 0; i < iw; i++) begin
      tick("fetch_wait", 1'b0, rb(), $urandom, rb(),
           mk(1, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0), M_CTL);
    end
    tick("fetch", 1'b1, rb(), ins, rb(),
         mk(1, 0, 0, 1, 1, 0, 3'b000, 0, 2'b00, 0, 0, 0), M_FETCH);
    tick("decode", rb(), rb(), $urandom, rb(), 15'h0000, M_CTL);

    if (!legal) begin
      for (int i = 0; i < 20; i++) begin
        tick("trap", rb(), rb(), $urandom, rb(),
             mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 1), M_CTL);
      end
      async_reset("trap_reset");
      return;
    end

    case (kind)
      K_BR: begin
        taken = (ins[14:12] == 3'b000) ? eqv : !eqv;
        e = mk(0, 0, 0, 0, taken, taken, 3'b001, 0, 2'b10, 0, 0, 0);
        tick("exec_br", rb(), rb(), $urandom, eqv, e, taken ? M_EXT : M_EXNT);
      end
      K_R, K_I: begin
        e = mk(0, 0, 0, 0, 0, 0, ac, (kind == K_I), 2'b00, 0, 0, 0);
        // ImmSrc is irrelevant for register-register ops.
        tick("exec_alu", rb(), rb(), $urandom, rb(), e,
             (kind == K_R) ? (M_EXNT & ~15'h0018) : M_EXNT);
        tick("wb_alu", rb(), rb(), $urandom, rb(),
             mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 1, 0, 0), M_WB);
      end
      default: begin
        is_sw = (kind == K_SW);
        imm   = is_sw ? 2'b01 : 2'b00;
        e = mk(0, 0, 0, 0, 0, 0, 3'b000, 1, imm, 0, 0, 0);
        tick("exec_mem", rb(), rb(), $urandom, rb(), e, M_EXNT);
        e = mk(0, 1, is_sw, 0, 0, 0, 3'b000, 1, imm, 0, 0, 0);
        for (int j = 0; j <= dw; j++) begin
          if (j == rst_at) begin
            imem_rdy = rb();
            dmem_rdy = rb();
            instr    = $urandom;
            EQ       = rb();
            #1 check_eq("mem_pre_reset", obs & M_EXNT, e & M_EXNT);
            async_reset("mem_reset");
            return;
          end
          tick("mem", rb(), (j == dw), $urandom, rb(), e, M_EXNT);
        end
        if (!is_sw) begin
          tick("wb_lw", rb(), rb(), $urandom, rb(),
               mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 1, 1, 0), M_WB);
        end
      end
    endcase
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [31:0] ins;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 10);
    case (k)
      0:  ins = {7'h00, r[24:15], 3'b000, r[11:7], 7'b0110011};
      1:  ins = {7'h20, r[24:15], 3'b000, r[11:7], 7'b0110011};
      2:  ins = {7'h00, r[24:15], 3'b111, r[11:7], 7'b0110011};
      3:  ins = {7'h00, r[24:15], 3'b110, r[11:7], 7'b0110011};
      4:  ins = {7'h00, r[24:15], 3'b010, r[11:7], 7'b0110011};
      5:  ins = {r[31:15], 3'b000, r[11:7], 7'b0010011};
      6:  ins = {r[31:15], 3'b010, r[11:7], 7'b0000011};
      7:  ins = {r[31:15], 3'b010, r[11:7], 7'b0100011};
      8:  ins = {r[31:15], 2'b00, r[12], r[11:7], 7'b1100011};
      9:  ins = {r[31:15], 2'b00, r[12], r[11:7], 7'b1100011};
      default: ins = r;
    endcase
    return ins;
  endfunction

  initial begin
    int dw;
    int rst_at;
    rst_n    = 1'b0;
    instr    = '0;
    imem_rdy = 1'b0;
    dmem_rdy = 1'b0;
    EQ       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outputs", obs, 15'h0000);
    imem_rdy = 1'b1;
    dmem_rdy = 1'b1;
    instr    = 32'h002081B3;
    #1 check_eq("reset_rdy_ignored", obs, 15'h0000);
    @(posedge clk);
    #1 check_eq("reset_after_edge", obs, 15'h0000);
    rst_n = 1'b1;
    tick("idle", 1'b1, 1'b1, 32'h002081B3, 1'b1, 15'h0000, M_ALL);

    // Directed cases.
    run_instr(32'h002081B3, 0, 0, 1'b0, -1);  // add
    run_instr(32'h402081B3, 1, 0, 1'b0, -1);  // sub with one imem wait
    run_instr(32'h0080A283, 0, 2, 1'b0, -1);  // lw, dmem two waits
    run_instr(32'h0020A423, 0, 0, 1'b0, -1);  // sw
    run_instr(32'h00208463, 0, 0, 1'b1, -1);  // beq taken
    run_instr(32'h00208463, 0, 0, 1'b0, -1);  // beq not taken
    run_instr(32'h00209463, 0, 0, 1'b0, -1);  // bne taken
    run_instr(32'h00209463, 2, 0, 1'b1, -1);  // bne not taken
    run_instr(32'h0080A283, 1, 3, 1'b0, 1);   // lw with reset mid-MEM
    run_instr(32'h022081B3, 0, 0, 1'b0, -1);  // funct7 0x01 -> trap
    run_instr(32'h00000000, 0, 0, 1'b0, -1);  // all-zero word -> trap

    // Random instructions, waits and occasional mid-MEM resets.
    for (int n = 0; n < 150; n++) begin
      dw     = $urandom_range(0, 3);
      rst_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, dw)) : -1;
      run_instr(gen_instr(), $urandom_range(0, 2), dw, rb(), rst_at);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
